// File: rtl/lcd_cmd_queue.sv
// Command FIFO that feeds LCD_CTRL one command at a time, issuing only while busy is low.
// Define LCD_CMDQ_STAT_EN to build the 16-bit issued-command counter on issued_cnt.
module lcd_cmd_queue #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned CMD_W = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [CMD_W-1:0]           host_cmd,
  input  logic                       host_valid,
  output logic                       host_ready,
  input  logic                       flush,
  output logic [CMD_W-1:0]           cmd,
  output logic                       cmd_valid,
  input  logic                       busy,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       empty,
  output logic                       overflow,
  output logic [15:0]                issued_cnt
);

  localparam int unsigned LvlW = $clog2(DEPTH + 1);
  localparam int unsigned PtrW = $clog2(DEPTH);

  typedef enum logic [0:0] {StIdle, StGuard} state_e;

  state_e           state_q;
  logic [CMD_W-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [LvlW-1:0]  level_q, level_d;
  logic             overflow_q;
  logic [CMD_W-1:0] cmd_q;
  logic             cmd_valid_q;

  logic push, drop, issue;

  assign level      = level_q;
  assign empty      = (level_q == '0);
  // No write-through: a full queue refuses even when a pop happens this cycle.
  assign host_ready = (level_q != LvlW'(DEPTH));
  assign overflow   = overflow_q;
  assign cmd        = cmd_q;
  assign cmd_valid  = cmd_valid_q;

  always_comb begin
    push  = host_valid && host_ready && !flush;
    drop  = host_valid && !host_ready && !flush;
    issue = (state_q == StIdle) && !empty && !busy && !flush;
    level_d = level_q;
    unique case ({push, issue})
      2'b10:   level_d = level_q + LvlW'(1);
      2'b01:   level_d = level_q - LvlW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= host_cmd;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      overflow_q  <= 1'b0;
      cmd_q       <= '0;
      cmd_valid_q <= 1'b0;
    end else if (flush) begin
      // cmd keeps the last issued value across a flush.
      state_q     <= StIdle;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      overflow_q  <= 1'b0;
      cmd_valid_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (issue) rd_ptr_q <= rd_ptr_q + PtrW'(1);
      if (drop) overflow_q <= 1'b1;
      level_q <= level_d;
      unique case (state_q)
        StIdle: begin
          if (issue) begin
            cmd_q       <= mem_q[rd_ptr_q];
            cmd_valid_q <= 1'b1;
            state_q     <= StGuard;
          end else begin
            cmd_valid_q <= 1'b0;
          end
        end
        StGuard: begin
          // Covers the cycle before LCD_CTRL gets busy raised.
          cmd_valid_q <= 1'b0;
          state_q     <= StIdle;
        end
        default: begin
          cmd_valid_q <= 1'b0;
          state_q     <= StIdle;
        end
      endcase
    end
  end

`ifdef LCD_CMDQ_STAT_EN
  logic [15:0] issued_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      issued_cnt_q <= '0;
    end else if (issue) begin
      issued_cnt_q <= issued_cnt_q + 16'd1;
    end
  end

  assign issued_cnt = issued_cnt_q;
`else
  assign issued_cnt = '0;
`endif

endmodule

// File: tb/tb_lcd_cmd_queue.sv
// Directed bench for lcd_cmd_queue: vector table plus a modelled continuous-push run
// and a reset-mid-burst sequence.
module tb_lcd_cmd_queue;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned CMD_W = 4;

  logic             clk = 1'b0;
  logic             reset, host_valid, flush, busy;
  logic [CMD_W-1:0] host_cmd;
  logic             host_ready, cmd_valid, empty, overflow;
  logic [CMD_W-1:0] cmd;
  logic [3:0]       level;
  logic [15:0]      issued_cnt;

  int n_vec  = 0;
  int n_miss = 0;

  lcd_cmd_queue #(.DEPTH(DEPTH), .CMD_W(CMD_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .host_cmd   (host_cmd),
    .host_valid (host_valid),
    .host_ready (host_ready),
    .flush      (flush),
    .cmd        (cmd),
    .cmd_valid  (cmd_valid),
    .busy       (busy),
    .level      (level),
    .empty      (empty),
    .overflow   (overflow),
    .issued_cnt (issued_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst, hv, fl, bz;
    logic [3:0] hc;
    logic       cv;
    logic [3:0] c;
    logic [3:0] lv;
    logic       ov;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic rst, input logic hv, input logic [3:0] hc,
                              input logic fl, input logic bz, input logic cv,
                              input logic [3:0] c, input logic [3:0] lv, input logic ov);
    vec_t v;
    v.rst = rst; v.hv = hv; v.hc = hc; v.fl = fl; v.bz = bz;
    v.cv = cv; v.c = c; v.lv = lv; v.ov = ov;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input logic rst, input logic hv, input logic [3:0] hc,
                      input logic fl, input logic bz);
    reset = rst; host_valid = hv; host_cmd = hc; flush = fl; busy = bz;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] exp_stat(input logic [15:0] n);
`ifdef LCD_CMDQ_STAT_EN
    return n;
`else
    return 16'd0;
`endif
  endfunction

  initial begin
    logic [15:0] exp_cnt;
    logic [3:0]  q[$];
    logic [3:0]  ml, hc, expc;
    logic        ms_guard, mov, pop, acc;
    vec_t        v;

    reset = 1'b1; host_valid = 1'b0; host_cmd = '0; flush = 1'b0; busy = 1'b0;

    // rst hv hc fl bz | cv cmd lvl ovf
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 3, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(0, 1, 1, 0, 0, 1, 3, 1, 0));
    tbl.push_back(mk(0, 1, 2, 0, 0, 0, 3, 2, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 1, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 2, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 2, 0, 0));
    for (int k = 0; k < 8; k++) tbl.push_back(mk(0, 1, 4'(k), 0, 1, 0, 2, 4'(k + 1), 0));
    tbl.push_back(mk(0, 1, 15, 0, 1, 0, 2, 8, 1));
    for (int k = 0; k < 8; k++) begin
      tbl.push_back(mk(0, 0, 0, 0, 0, 1, 4'(k), 4'(7 - k), 1));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 4'(k), 4'(7 - k), 1));
    end
    tbl.push_back(mk(0, 0, 0, 1, 0, 0, 7, 0, 0));
    tbl.push_back(mk(0, 1, 5, 0, 0, 0, 7, 1, 0));
    tbl.push_back(mk(0, 1, 6, 0, 0, 1, 5, 1, 0));
    for (int k = 0; k < 4; k++) tbl.push_back(mk(0, 0, 0, 0, 1, 0, 5, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 6, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 6, 0, 0));
    for (int k = 1; k <= 4; k++) tbl.push_back(mk(0, 1, 4'(k), 0, 1, 0, 6, 4'(k), 0));
    tbl.push_back(mk(0, 1, 9, 1, 0, 0, 6, 0, 0));
    for (int k = 0; k < 3; k++) tbl.push_back(mk(0, 0, 0, 0, 0, 0, 6, 0, 0));

    exp_cnt = '0;
    foreach (tbl[i]) begin
      v = tbl[i];
      step(v.rst, v.hv, v.hc, v.fl, v.bz);
      n_vec++;
      if (v.rst) exp_cnt = '0;
      else if (v.cv) exp_cnt++;
      check($sformatf("v%0d cmd_valid", i), cmd_valid, v.cv);
      check($sformatf("v%0d cmd", i), cmd, v.c);
      check($sformatf("v%0d level", i), level, v.lv);
      check($sformatf("v%0d host_ready", i), host_ready, v.lv != 4'd8);
      check($sformatf("v%0d empty", i), empty, v.lv == 4'd0);
      check($sformatf("v%0d overflow", i), overflow, v.ov);
      check($sformatf("v%0d issued_cnt", i), issued_cnt, exp_stat(exp_cnt));
    end

    // Continuous push with busy low: pointer wrap, fill, drop, and order check.
    ml = '0; ms_guard = 1'b0; mov = 1'b0; expc = '0;
    for (int c = 0; c < 60; c++) begin
      if (c >= 20 && ml == 0 && !ms_guard) break;
      hc  = 4'(c * 7 + 3);
      pop = !ms_guard && (ml != 0);
      acc = (c < 20) && (ml != 4'd8);
      if (c < 20 && !acc) mov = 1'b1;
      step(1'b0, c < 20, hc, 1'b0, 1'b0);
      n_vec++;
      if (pop) begin
        expc = q.pop_front();
        exp_cnt++;
      end
      if (acc) q.push_back(hc);
      ml = ml + 4'(acc) - 4'(pop);
      ms_guard = pop;
      check($sformatf("cont%0d cmd_valid", c), cmd_valid, pop);
      if (pop) check($sformatf("cont%0d cmd", c), cmd, expc);
      check($sformatf("cont%0d level", c), level, ml);
      check($sformatf("cont%0d host_ready", c), host_ready, ml != 4'd8);
    end
    check("cont drained level", level, 0);
    check("cont overflow", overflow, mov);
    check("cont issued_cnt", issued_cnt, exp_stat(exp_cnt));

    // Reset mid-burst clears everything including cmd and the counter.
    for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 4'(k + 10), 1'b0, 1'b1);
    check("burst level", level, 3);
    step(1'b1, 1'b1, 4'd5, 1'b0, 1'b0);
    n_vec++;
    check("rst level", level, 0);
    check("rst empty", empty, 1);
    check("rst cmd_valid", cmd_valid, 0);
    check("rst cmd", cmd, 0);
    check("rst overflow", overflow, 0);
    check("rst issued_cnt", issued_cnt, 0);
    step(1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    n_vec++;
    check("post-rst cmd_valid", cmd_valid, 0);
    check("post-rst level", level, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
